// File: rtl/triangle_decoder.sv
// Triangle-wave stream checker: tracks direction, flags peaks/troughs,
// measures trough-to-trough period and latches a sticky fault on illegal steps.
module triangle_decoder #(
  parameter int N  = 8,
  parameter int PW = N + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic [N-1:0]  sample,
  output logic          dir,
  output logic          locked,
  output logic          peak,
  output logic          trough,
  output logic [PW-1:0] period,
  output logic          period_valid,
  output logic          fault
);

  localparam logic [2:0] S_EMPTY = 3'd0;
  localparam logic [2:0] S_ACQ   = 3'd1;
  localparam logic [2:0] S_UP    = 3'd2;
  localparam logic [2:0] S_DOWN  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  localparam logic [N:0]    ONE_W   = {{N{1'b0}}, 1'b1};
  localparam logic [N:0]    MAX_W   = {1'b0, {N{1'b1}}};
  localparam logic [PW-1:0] CNT_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] CNT_MAX = {PW{1'b1}};

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [N-1:0]  prev;
  logic [PW-1:0] count;
  logic          armed;
  logic [N:0]    prev_w;
  logic [N:0]    sample_w;
  logic          step_up;
  logic          step_down;
  logic          at_max;
  logic          at_zero;
  logic          peak_nxt;
  logic          trough_nxt;

  // Widened by one bit so MAX+1 and 0-1 never alias onto legal samples.
  assign prev_w    = {1'b0, prev};
  assign sample_w  = {1'b0, sample};
  assign step_up   = (sample_w == prev_w + ONE_W) && (prev_w != MAX_W);
  assign step_down = (sample_w == prev_w - ONE_W) && (prev != '0);
  assign at_max    = (sample == {N{1'b1}});
  assign at_zero   = (sample == '0);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt  = state;
    peak_nxt   = 1'b0;
    trough_nxt = 1'b0;
    case (state)
      S_EMPTY: state_nxt = S_ACQ;
      S_ACQ: begin
        if (step_up) begin
          state_nxt = at_max ? S_DOWN : S_UP;
          peak_nxt  = at_max;
        end else if (step_down) begin
          state_nxt  = at_zero ? S_UP : S_DOWN;
          trough_nxt = at_zero;
        end else begin
          state_nxt = S_FAULT;
        end
      end
      S_UP: begin
        if (step_up) begin
          state_nxt = at_max ? S_DOWN : S_UP;
          peak_nxt  = at_max;
        end else begin
          state_nxt = S_FAULT;
        end
      end
      S_DOWN: begin
        if (step_down) begin
          state_nxt  = at_zero ? S_UP : S_DOWN;
          trough_nxt = at_zero;
        end else begin
          state_nxt = S_FAULT;
        end
      end
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state        <= S_EMPTY;
      prev         <= '0;
      count        <= '0;
      armed        <= 1'b0;
      dir          <= 1'b0;
      locked       <= 1'b0;
      peak         <= 1'b0;
      trough       <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      fault        <= 1'b0;
    end else begin
      peak         <= 1'b0;
      trough       <= 1'b0;
      period_valid <= 1'b0;
      if (ena && state != S_FAULT) begin
        state  <= state_nxt;
        prev   <= sample;
        peak   <= peak_nxt;
        trough <= trough_nxt;
        locked <= (state_nxt == S_UP) || (state_nxt == S_DOWN);
        fault  <= (state_nxt == S_FAULT);
        if (state_nxt == S_UP)   dir <= 1'b1;
        if (state_nxt == S_DOWN) dir <= 1'b0;

        // The trough sample itself starts the next period, hence the reload to one.
        if (trough_nxt) begin
          if (armed) begin
            period       <= count;
            period_valid <= 1'b1;
          end
          count <= CNT_ONE;
          armed <= 1'b1;
        end else if ((state == S_UP || state == S_DOWN) && count != CNT_MAX) begin
          count <= count + CNT_ONE;
        end
        if (state_nxt == S_FAULT) armed <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_triangle_decoder.sv
// Directed bench for triangle_decoder (N=3): the driver queues expected outputs
// after each edge, a negedge monitor pops and compares them.
module tb_triangle_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [2:0] sample;
  logic       dir;
  logic       locked;
  logic       peak;
  logic       trough;
  logic [3:0] period;
  logic       period_valid;
  logic       fault;

  typedef struct packed {
    logic       dir;
    logic       locked;
    logic       peak;
    logic       trough;
    logic [3:0] period;
    logic       pv;
    logic       fault;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;

  // Running expectation for the held outputs; pulses are passed per step.
  logic       e_dir;
  logic       e_locked;
  logic [3:0] e_period;
  logic       e_fault;

  triangle_decoder #(.N(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .sample       (sample),
    .dir          (dir),
    .locked       (locked),
    .peak         (peak),
    .trough       (trough),
    .period       (period),
    .period_valid (period_valid),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t  e;
    exp_t  g;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      g.dir    = dir;
      g.locked = locked;
      g.peak   = peak;
      g.trough = trough;
      g.period = period;
      g.pv     = period_valid;
      g.fault  = fault;
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL %s: got dir=%0b locked=%0b peak=%0b trough=%0b period=%0d pv=%0b fault=%0b, want dir=%0b locked=%0b peak=%0b trough=%0b period=%0d pv=%0b fault=%0b",
                 nm, g.dir, g.locked, g.peak, g.trough, g.period, g.pv, g.fault,
                 e.dir, e.locked, e.peak, e.trough, e.period, e.pv, e.fault);
      end
    end
  end

  task automatic step(input logic r, input logic e, input logic [2:0] s,
                      input logic pk, input logic tr, input logic pv, input string nm);
    exp_t x;
    #1;
    rst    = r;
    ena    = e;
    sample = s;
    @(posedge clk);
    x.dir    = e_dir;
    x.locked = e_locked;
    x.peak   = pk;
    x.trough = tr;
    x.period = e_period;
    x.pv     = pv;
    x.fault  = e_fault;
    exp_q.push_back(x);
    name_q.push_back(nm);
  endtask

  task automatic do_reset(input string nm);
    e_dir    = 1'b0;
    e_locked = 1'b0;
    e_period = 4'd0;
    e_fault  = 1'b0;
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, nm);
  endtask

  task automatic sample_in(input logic [2:0] s, input logic pk, input logic tr,
                           input logic pv, input string nm);
    step(1'b0, 1'b1, s, pk, tr, pv, nm);
  endtask

  // Two full 0..7..0 swings; gap idle (ena low, garbage sample) cycles after each sample.
  task automatic sweep(input int gap, input string nm);
    logic [2:0] seq[$];
    logic [2:0] s;
    logic [2:0] last;
    logic       pk;
    logic       tr;
    logic       pv;
    int         troughs;
    for (int r = 0; r < 2; r++) begin
      for (int v = (r == 0) ? 0 : 1; v <= 7; v++) seq.push_back(3'(v));
      for (int v = 6; v >= 0; v--) seq.push_back(3'(v));
    end
    troughs = 0;
    last    = 3'd0;
    for (int i = 0; i < seq.size(); i++) begin
      s  = seq[i];
      pk = (s == 3'd7);
      tr = (s == 3'd0) && (i > 0);
      if (tr) troughs++;
      pv = tr && (troughs == 2);
      if (i >= 1) e_locked = 1'b1;
      if (pk)          e_dir = 1'b0;
      else if (tr)     e_dir = 1'b1;
      else if (i >= 1) e_dir = (s > last);
      if (pv) e_period = 4'd14;
      sample_in(s, pk, tr, pv, nm);
      last = s;
      for (int g = 0; g < gap; g++)
        step(1'b0, 1'b0, 3'(i * 5 + g + 3), 1'b0, 1'b0, 1'b0, {nm, "_idle"});
    end
  endtask

  initial begin
    rst    = 1'b1;
    ena    = 1'b0;
    sample = 3'd0;
    do_reset("reset_state");

    // Full legal swing, no gaps.
    sweep(0, "sweep");

    // Start falling from mid-range, then first trough only arms.
    do_reset("reset_t2");
    sample_in(3'd5, 0, 0, 0, "t2_acq");
    e_locked = 1'b1; e_dir = 1'b0;
    sample_in(3'd4, 0, 0, 0, "t2_down");
    sample_in(3'd3, 0, 0, 0, "t2_down3");
    sample_in(3'd2, 0, 0, 0, "t2_down2");
    sample_in(3'd1, 0, 0, 0, "t2_down1");
    e_dir = 1'b1;
    sample_in(3'd0, 0, 1, 0, "t2_first_trough");

    // Skip step faults; fault is sticky and legal samples are ignored.
    do_reset("reset_t3");
    sample_in(3'd3, 0, 0, 0, "t3_acq");
    e_locked = 1'b1; e_dir = 1'b1;
    sample_in(3'd4, 0, 0, 0, "t3_up");
    e_locked = 1'b0; e_fault = 1'b1;
    sample_in(3'd6, 0, 0, 0, "t3_skip_fault");
    sample_in(3'd7, 0, 0, 0, "t3_sticky_7");
    sample_in(3'd6, 0, 0, 0, "t3_sticky_6");
    do_reset("t3_reset_clears");

    // Wrap attempt and repeated sample.
    sample_in(3'd7, 0, 0, 0, "t4_acq7");
    e_fault = 1'b1;
    sample_in(3'd0, 0, 0, 0, "t4_wrap_fault");
    do_reset("reset_t4b");
    sample_in(3'd2, 0, 0, 0, "t4_acq2");
    e_fault = 1'b1;
    sample_in(3'd2, 0, 0, 0, "t4_delta0_fault");

    // Same swing with ena gaps; then a bad step keeps the measured period.
    do_reset("reset_t5");
    sweep(3, "gap_sweep");
    e_locked = 1'b0; e_fault = 1'b1;
    sample_in(3'd5, 0, 0, 0, "t5_fault_holds_period");

    // Reset wins over ena mid-UP; decoder restarts from EMPTY.
    do_reset("reset_t6");
    sample_in(3'd0, 0, 0, 0, "t6_acq");
    e_locked = 1'b1; e_dir = 1'b1;
    for (int v = 1; v <= 4; v++) sample_in(3'(v), 0, 0, 0, "t6_up");
    e_locked = 1'b0; e_dir = 1'b0;
    step(1'b1, 1'b1, 3'd5, 0, 0, 0, "t6_rst_with_ena");
    sample_in(3'd2, 0, 0, 0, "t6_reacq");
    e_locked = 1'b1;
    sample_in(3'd1, 0, 0, 0, "t6_down");

    // Peak and trough reached straight out of ACQ.
    do_reset("reset_t7");
    sample_in(3'd6, 0, 0, 0, "t7_acq6");
    e_locked = 1'b1; e_dir = 1'b0;
    sample_in(3'd7, 1, 0, 0, "t7_acq_peak");
    sample_in(3'd6, 0, 0, 0, "t7_down");
    do_reset("reset_t7b");
    sample_in(3'd1, 0, 0, 0, "t7_acq1");
    e_locked = 1'b1; e_dir = 1'b1;
    sample_in(3'd0, 0, 1, 0, "t7_acq_trough");

    #1;
    ena = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
